// File: rtl/layer_sequencer.sv
// Drives a chain of NUM_LAYERS matmul layers through one forward pass, then backprop in reverse order.
// Optional watchdog on every layer wait is compiled in with `define SEQ_TIMEOUT_EN.
module layer_sequencer #(
  parameter int NUM_LAYERS  = 3,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [62:0]               sample_in,
  input  logic [62:0]               target_in,
  output logic                      busy,
  output logic                      done,
  output logic [62:0]               result_out,
  output logic                      err,
  output logic [NUM_LAYERS-1:0]     l_mult,
  output logic [NUM_LAYERS-1:0]     l_backprop,
  output logic [NUM_LAYERS-1:0]     l_ack,
  output logic [NUM_LAYERS-1:0]     l_output_layer,
  input  logic [NUM_LAYERS-1:0]     l_valid,
  output logic [63*NUM_LAYERS-1:0]  l_in,
  input  logic [63*NUM_LAYERS-1:0]  l_out,
  output logic [3:0]                dbg_state
);

  // Layer handshake: a layer result is taken on the first cycle l_valid[cur] is
  // seen in a WAIT state; l_ack[cur] then stays high until l_valid[cur] drops.
  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FWD_ISSUE = 4'd1,
    S_FWD_WAIT  = 4'd2,
    S_FWD_ACK   = 4'd3,
    S_BWD_ISSUE = 4'd4,
    S_BWD_WAIT  = 4'd5,
    S_BWD_ACK   = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam logic [1:0] LAST = 2'(NUM_LAYERS - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [1:0]              r_cur;
  logic [62:0]             r_vec;
  logic [62:0]             r_result;
  logic [62:0]             r_l_in [NUM_LAYERS];
  logic [NUM_LAYERS-1:0]   r_l_ack;
  logic [NUM_LAYERS-1:0]   w_cur_onehot;
  logic                    w_valid_cur;
  logic [62:0]             w_out_cur;
  logic                    w_tmo_hit;
  logic                    w_lin_we;
  logic [1:0]              w_lin_idx;
  logic [62:0]             w_lin_val;

  always_comb begin
    w_valid_cur  = 1'b0;
    w_out_cur    = '0;
    w_cur_onehot = '0;
    for (int n = 0; n < NUM_LAYERS; n++) begin
      if (r_cur == 2'(n)) begin
        w_valid_cur     = l_valid[n];
        w_out_cur       = l_out[63*n +: 63];
        w_cur_onehot[n] = 1'b1;
      end
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

  logic [TW-1:0] r_tmo;
  logic          r_err;
  logic          w_in_wait;

  assign w_in_wait = (r_state == S_FWD_WAIT) || (r_state == S_FWD_ACK) ||
                     (r_state == S_BWD_WAIT) || (r_state == S_BWD_ACK);
  assign w_tmo_hit = w_in_wait && (r_tmo == TW'(TIMEOUT_CYC - 1));

  // Any state change restarts the count, so each wait/ack phase gets its own budget.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_next != r_state) begin
      r_tmo <= '0;
    end else if (w_in_wait) begin
      r_tmo <= r_tmo + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_next == S_ERROR) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  // Watchdog compiled out: never fires, waits are unbounded.
  assign w_tmo_hit = (TIMEOUT_CYC < 0);
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    busy       = 1'b1;
    done       = 1'b0;
    l_mult     = '0;
    l_backprop = '0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) w_next = S_FWD_ISSUE;
      end
      S_FWD_ISSUE: begin
        l_mult = w_cur_onehot;
        w_next = S_FWD_WAIT;
      end
      S_FWD_WAIT: begin
        if (w_valid_cur)    w_next = S_FWD_ACK;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_FWD_ACK: begin
        if (!w_valid_cur)   w_next = (r_cur == LAST) ? S_BWD_ISSUE : S_FWD_ISSUE;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_BWD_ISSUE: begin
        l_backprop = w_cur_onehot;
        w_next     = S_BWD_WAIT;
      end
      S_BWD_WAIT: begin
        if (w_valid_cur)    w_next = S_BWD_ACK;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_BWD_ACK: begin
        if (!w_valid_cur)   w_next = (r_cur == 2'd0) ? S_DONE : S_BWD_ISSUE;
        else if (w_tmo_hit) w_next = S_ERROR;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      S_ERROR: begin
        busy   = 1'b0;
        w_next = S_ERROR;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // l_in of the next layer is loaded as soon as its input is known, so it is
  // already stable at least one cycle before that layer's start strobe.
  always_comb begin
    w_lin_we  = 1'b0;
    w_lin_idx = r_cur;
    w_lin_val = w_out_cur;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_lin_we  = 1'b1;
          w_lin_idx = 2'd0;
          w_lin_val = sample_in;
        end
      end
      S_FWD_WAIT: begin
        if (w_valid_cur) begin
          w_lin_we = 1'b1;
          if (r_cur != LAST) w_lin_idx = r_cur + 2'd1;
          else               w_lin_val = target_in;
        end
      end
      S_FWD_ACK: begin
        if (r_cur == LAST) begin
          w_lin_we  = 1'b1;
          w_lin_val = target_in;
        end
      end
      S_BWD_WAIT: begin
        if (w_valid_cur && (r_cur != 2'd0)) begin
          w_lin_we  = 1'b1;
          w_lin_idx = r_cur - 2'd1;
        end
      end
      default: begin
        w_lin_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cur    <= 2'd0;
      r_vec    <= '0;
      r_result <= '0;
      r_l_ack  <= '0;
      for (int n = 0; n < NUM_LAYERS; n++) r_l_in[n] <= '0;
    end else begin
      for (int n = 0; n < NUM_LAYERS; n++) begin
        if (w_lin_we && (w_lin_idx == 2'(n))) r_l_in[n] <= w_lin_val;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cur <= 2'd0;
            r_vec <= sample_in;
          end
        end
        S_FWD_WAIT, S_BWD_WAIT: begin
          if (w_valid_cur) begin
            r_vec   <= w_out_cur;
            r_l_ack <= w_cur_onehot;
          end
        end
        S_FWD_ACK: begin
          if (w_next != S_FWD_ACK) r_l_ack <= '0;
          if (w_next == S_FWD_ISSUE) r_cur <= r_cur + 2'd1;
          if (w_next == S_BWD_ISSUE) begin
            r_result <= r_vec;
            r_vec    <= target_in;
          end
        end
        S_BWD_ACK: begin
          if (w_next != S_BWD_ACK) r_l_ack <= '0;
          if (w_next == S_BWD_ISSUE) r_cur <= r_cur - 2'd1;
        end
        default: begin
          r_l_ack <= '0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lin
    assign l_in[63*g +: 63] = r_l_in[g];
  end

  assign l_ack          = r_l_ack;
  assign result_out     = r_result;
  assign l_output_layer = {1'b1, {(NUM_LAYERS-1){1'b0}}};
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer with two behavioural layers that add 1 to every 7-bit element.
module tb_layer_sequencer;
  localparam int NL = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [62:0]       sample_in;
  logic [62:0]       target_in;
  logic              busy;
  logic              done;
  logic [62:0]       result_out;
  logic              err;
  logic [NL-1:0]     l_mult;
  logic [NL-1:0]     l_backprop;
  logic [NL-1:0]     l_ack;
  logic [NL-1:0]     l_output_layer;
  logic [NL-1:0]     l_valid;
  logic [63*NL-1:0]  l_in;
  logic [63*NL-1:0]  l_out;
  logic [3:0]        dbg_state;

  always #5 clk = ~clk;

  layer_sequencer #(.NUM_LAYERS(NL), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .reset(reset), .start(start), .sample_in(sample_in), .target_in(target_in),
    .busy(busy), .done(done), .result_out(result_out), .err(err),
    .l_mult(l_mult), .l_backprop(l_backprop), .l_ack(l_ack), .l_output_layer(l_output_layer),
    .l_valid(l_valid), .l_in(l_in), .l_out(l_out), .dbg_state(dbg_state)
  );

  // ---------------- layer models ----------------
  logic [NL-1:0] m_vld;
  logic [NL-1:0] spur;
  logic [NL-1:0] kill;
  logic [62:0]   m_out [NL];
  logic [62:0]   m_cap [NL];
  int            m_cnt [NL];
  int            m_ackseen [NL];
  int            ack_run [NL];
  int            hold_cfg;
  int            delay_cfg;
  int            done_cnt;
  int            multihot;
  int            checks;
  int            failures;

  logic [65:0]   exp_q[$];
  logic [65:0]   got_q[$];
  int            ack_q[$];

  assign l_valid = m_vld | spur;
  for (genvar g = 0; g < NL; g++) begin : g_out
    assign l_out[63*g +: 63] = m_out[g];
  end

  function automatic logic [62:0] inc7(input logic [62:0] v);
    logic [62:0] r;
    for (int k = 0; k < 9; k++) r[7*k +: 7] = v[7*k +: 7] + 7'd1;
    return r;
  endfunction

  initial begin
    m_vld = '0;
    for (int n = 0; n < NL; n++) begin
      m_out[n] = '0; m_cap[n] = '0; m_cnt[n] = 0; m_ackseen[n] = 0; ack_run[n] = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      m_vld = '0;
      for (int n = 0; n < NL; n++) begin
        m_cnt[n] = 0; m_ackseen[n] = 0; ack_run[n] = 0;
      end
    end else begin
      if (done) done_cnt++;
      if (($countones(l_mult) > 1) || ($countones(l_backprop) > 1) || ($countones(l_ack) > 1)) multihot++;
      for (int n = 0; n < NL; n++) begin
        if (l_mult[n])     got_q.push_back({1'b0, 2'(n), l_in[63*n +: 63]});
        if (l_backprop[n]) got_q.push_back({1'b1, 2'(n), l_in[63*n +: 63]});
        if (l_ack[n]) ack_run[n]++;
        else if (ack_run[n] != 0) begin
          ack_q.push_back(ack_run[n]);
          ack_run[n] = 0;
        end
        if (m_cnt[n] == 0 && !m_vld[n] && (l_mult[n] || l_backprop[n]) && !kill[n]) begin
          m_cap[n]     = inc7(l_in[63*n +: 63]);
          m_cnt[n]     = delay_cfg;
          m_ackseen[n] = 0;
        end else if (m_cnt[n] > 0) begin
          m_cnt[n]--;
          if (m_cnt[n] == 0) begin
            m_vld[n] = 1'b1;
            m_out[n] = m_cap[n];
          end
        end else if (m_vld[n] && l_ack[n]) begin
          m_ackseen[n]++;
          if (m_ackseen[n] >= hold_cfg) m_vld[n] = 1'b0;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic launch(input logic [62:0] s, input logic [62:0] t, input int hold);
    hold_cfg = hold;
    got_q.delete();
    ack_q.delete();
    @(negedge clk);
    sample_in = s;
    target_in = t;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int d0);
    int k = 0;
    while (done_cnt == d0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, (done_cnt != d0), 1'b1);
  endtask

  task automatic wait_state(input string name, input logic [3:0] st);
    int k = 0;
    while (dbg_state != st && k < 400) begin
      @(negedge clk);
      k++;
    end
    check(name, dbg_state, st);
  endtask

  task automatic check_pass(input string tag, input logic [62:0] s, input logic [62:0] t,
                            input logic [62:0] fwd1, input logic [62:0] res,
                            input logic [62:0] bwd0, input int hold, input int d0);
    exp_q.delete();
    exp_q.push_back({1'b0, 2'd0, s});
    exp_q.push_back({1'b0, 2'd1, fwd1});
    exp_q.push_back({1'b1, 2'd1, t});
    exp_q.push_back({1'b1, 2'd0, bwd0});
    check({tag, "_events"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    check({tag, "_acks"}, ack_q.size(), 4);
    for (int i = 0; i < ack_q.size(); i++)
      check($sformatf("%s_acklen%0d", tag, i), ack_q[i], hold);
    check({tag, "_result"}, result_out, res);
    check({tag, "_done_once"}, done_cnt - d0, 1);
    check({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  typedef struct {
    logic [62:0] sample;
    logic [62:0] target;
    logic [62:0] fwd1;
    logic [62:0] result;
    logic [62:0] bwd0;
    int          hold;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int d0;
    int nwait;
    reset = 1'b1; start = 1'b0; sample_in = '0; target_in = '0;
    spur = '0; kill = '0; hold_cfg = 1; delay_cfg = 3;
    done_cnt = 0; multihot = 0; checks = 0; failures = 0;

    tbl[0] = '{{9{7'd5}},   {9{7'd33}},  {9{7'd6}},   {9{7'd7}}, {9{7'd34}}, 1};
    tbl[1] = '{63'd0,       {9{7'd1}},   {9{7'd1}},   {9{7'd2}}, {9{7'd2}},  1};
    tbl[2] = '{{9{7'd126}}, {9{7'd127}}, {9{7'd127}}, 63'd0,     63'd0,      4};
    tbl[3] = '{{7'd3, {4{7'd100, 7'd127}}}, {{4{7'd64, 7'd9}}, 7'd0},
               {7'd4, {4{7'd101, 7'd0}}},   {7'd5, {4{7'd102, 7'd1}}},
               {{4{7'd65, 7'd10}}, 7'd1}, 2};

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_strobes", {l_mult, l_backprop, l_ack}, '0);
    check("rst_l_in", l_in, '0);
    check("rst_result", result_out, '0);
    check("rst_state", dbg_state, 4'd0);
    check("output_layer", l_output_layer, 2'b10);
    reset = 1'b0;

    for (int i = 0; i < 4; i++) begin
      d0 = done_cnt;
      launch(tbl[i].sample, tbl[i].target, tbl[i].hold);
      wait_done($sformatf("t%0d_done_seen", i), d0);
      repeat (3) @(negedge clk);
      check_pass($sformatf("t%0d", i), tbl[i].sample, tbl[i].target, tbl[i].fwd1,
                 tbl[i].result, tbl[i].bwd0, tbl[i].hold, d0);
    end

    // Spurious valid on layer 0 while layer 1 is waiting must be ignored.
    d0 = done_cnt;
    launch(tbl[0].sample, tbl[0].target, 1);
    nwait = 0;
    while (got_q.size() < 2 && nwait < 200) begin
      @(negedge clk);
      nwait++;
    end
    spur[0] = 1'b1;
    @(negedge clk);
    check("spur_still_wait", dbg_state, 4'd2);
    spur[0] = 1'b0;
    wait_done("spur_done_seen", d0);
    repeat (3) @(negedge clk);
    check_pass("spur", tbl[0].sample, tbl[0].target, tbl[0].fwd1, tbl[0].result, tbl[0].bwd0, 1, d0);

    // start during BWD_WAIT is ignored.
    d0 = done_cnt;
    launch(tbl[1].sample, tbl[1].target, 1);
    wait_state("bwd_wait_reached", 4'd5);
    sample_in = {9{7'd40}};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start_done_seen", d0);
    repeat (20) @(negedge clk);
    check("busy_start_done_once", done_cnt - d0, 1);
    check("busy_start_result", result_out, tbl[1].result);
    check("busy_start_idle", dbg_state, 4'd0);

    // Asynchronous reset while in FWD_ACK, then a full pass.
    d0 = done_cnt;
    launch(tbl[3].sample, tbl[3].target, 4);
    wait_state("fwd_ack_reached", 4'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_strobes", {l_mult, l_backprop, l_ack}, '0);
    check("arst_l_in", l_in, '0);
    check("arst_result", result_out, '0);
    check("arst_state", dbg_state, 4'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("arst_no_done", done_cnt - d0, 0);
    d0 = done_cnt;
    launch(tbl[2].sample, tbl[2].target, 1);
    wait_done("post_rst_done_seen", d0);
    repeat (3) @(negedge clk);
    check_pass("post_rst", tbl[2].sample, tbl[2].target, tbl[2].fwd1, tbl[2].result, tbl[2].bwd0, 1, d0);

`ifdef SEQ_TIMEOUT_EN
    // Layer 1 never answers: watchdog must fire after 255 cycles in FWD_WAIT.
    kill[1] = 1'b1;
    launch(tbl[0].sample, tbl[0].target, 1);
    nwait = 0;
    while (err == 1'b0 && nwait < 600) begin
      @(negedge clk);
      if (got_q.size() >= 2 && dbg_state == 4'd2) nwait++;
      else if (got_q.size() < 2) nwait = nwait + 0;
      if (nwait == 0 && got_q.size() < 2 && done_cnt > 1000) nwait = 600;
    end
    check("tmo_cycles", nwait, 255);
    repeat (5) @(negedge clk);
    check("tmo_err", err, 1'b1);
    check("tmo_busy", busy, 1'b0);
    check("tmo_state", dbg_state, 4'd8);
    check("tmo_strobes", {l_mult, l_backprop, l_ack}, '0);
    reset = 1'b1;
    kill  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("tmo_err_cleared", err, 1'b0);
`else
    check("err_tied_low", err, 1'b0);
`endif

    check("onehot_strobes", multihot, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 Parameter NUM_LAYERS, default 3, number of chained 9x7-bit matmul layers (legal 2..4).
REQ-002 Parameter TIMEOUT_CYC, default 255, watchdog limit in cycles (used only with SEQ_TIMEOUT_EN).
REQ-003 clk  input  1  single clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high.
REQ-005 start  input  1  begin one forward+backprop pass.
REQ-006 sample_in  input  63  packed 7x9 network input (element k at bits 7k+6:7k).
REQ-007 target_in  input  63  packed 7x9 expected output.
REQ-008 busy  output  1  pass in progress.
REQ-009 done  output  1  one-cycle pulse at pass completion.
REQ-010 result_out  output  63  last-layer forward output of most recent pass.
REQ-011 err  output  1  sticky watchdog error (SEQ_TIMEOUT_EN only, else tied 0).
REQ-012 l_mult  output  NUM_LAYERS  per-layer forward-start pulse.
REQ-013 l_backprop  output  NUM_LAYERS  per-layer backprop-start pulse.
REQ-014 l_ack  output  NUM_LAYERS  per-layer acknowledge.
REQ-015 l_output_layer  output  NUM_LAYERS  constant, only bit NUM_LAYERS-1 set.
REQ-016 l_valid  input  NUM_LAYERS  per-layer result valid.
REQ-017 l_in  output  63*NUM_LAYERS  packed input vector per layer, layer n at bits 63n+62:63n.
REQ-018 l_out  input  63*NUM_LAYERS  packed output vector per layer.

Function
REQ-019 States: IDLE, FWD_ISSUE, FWD_WAIT, FWD_ACK, BWD_ISSUE, BWD_WAIT, BWD_ACK, DONE, ERROR; 4-bit state, layer index cur 2 bits.
REQ-020 IDLE: start=1 -> cur=0, capture sample_in into vec register, go FWD_ISSUE; start while busy is ignored.
REQ-021 FWD_ISSUE: l_in[cur]=vec held stable; l_mult[cur]=1 for exactly one cycle; -> FWD_WAIT.
REQ-022 FWD_WAIT: on l_valid[cur]=1 capture l_out[cur] into vec, assert l_ack[cur] (registered) -> FWD_ACK.
REQ-023 FWD_ACK: hold l_ack[cur]=1 until l_valid[cur] samples 0, then drop ack; if cur<NUM_LAYERS-1: cur+1 -> FWD_ISSUE; else result_out<=vec, vec<=target_in, -> BWD_ISSUE.
REQ-024 BWD_ISSUE: l_in[cur]=vec driven one cycle before and during l_backprop[cur] pulse (layer samples input continuously while waiting); -> BWD_WAIT.
REQ-025 BWD_WAIT/BWD_ACK: same valid/ack rules as forward; captured l_out[cur] (delta) becomes vec; if cur>0: cur-1 -> BWD_ISSUE; else -> DONE.
REQ-026 DONE: done=1 one cycle, busy=0 next cycle, -> IDLE.
REQ-027 busy=1 in every state except IDLE and ERROR.
REQ-028 l_in for non-current layers SHALL hold last driven value; vectors passed unmodified, no arithmetic in block.
REQ-029 At most one bit of l_mult, l_backprop, l_ack set in any cycle.
REQ-030 l_valid on a non-current layer is ignored.

Reset
REQ-031 reset=1 asynchronously forces IDLE, cur=0, vec=0, l_in=0, result_out=0, busy=done=err=0, l_mult=l_backprop=l_ack=0.
REQ-032 Reset mid-pass abandons the pass with no done pulse; layers share the same reset.
REQ-033 l_output_layer is constant and unaffected by reset.

Configuration
REQ-034 Macro SEQ_TIMEOUT_EN defined: counter restarts on entering FWD_WAIT/BWD_WAIT/FWD_ACK/BWD_ACK; reaching TIMEOUT_CYC -> ERROR, err=1, all strobes 0; ERROR exits only via reset.
REQ-035 SEQ_TIMEOUT_EN undefined: no counter, ERROR unreachable, err tied 0, waits are unbounded.

Verification
REQ-036 NUM_LAYERS=2, layer model valid 3 cycles after mult, start with sample_in all 7'd5 -> l_mult[0], l_mult[1] pulse in order, l_in[1]=l_out[0], then l_backprop[1] with l_in[1]=target_in, then l_backprop[0], done pulse once.
REQ-037 Layer model echoes input+1 per element; sample 0 -> result_out elements = 2 after forward phase (NUM_LAYERS=2).
REQ-038 Model holds valid 4 cycles after ack -> l_ack stays 1 exactly those 4 cycles, no state advance.
REQ-039 start pulsed during BWD_WAIT -> ignored, exactly one done pulse.
REQ-040 reset asserted in FWD_ACK -> all outputs 0 same cycle (asynchronous), IDLE; next start runs full pass.
REQ-041 SEQ_TIMEOUT_EN, TIMEOUT_CYC=255, layer 1 never valid -> err=1 after 255 cycles in FWD_WAIT, busy=0, strobes 0 until reset.
